// File: rtl/sdiv_pkg.sv
// Purpose: shared widths, FSM encoding and saturation constants for the signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdiv_pkg;

    localparam int DEF_DIVIDEND_W = 54;
    localparam int DEF_DIVISOR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Saturation values for the quotient: +(2^(W-1)-1) and -2^(W-1).
    localparam logic [DEF_DIVIDEND_W-1:0] SQ_MAX = {1'b0, {(DEF_DIVIDEND_W-1){1'b1}}};
    localparam logic [DEF_DIVIDEND_W-1:0] SQ_MIN = {1'b1, {(DEF_DIVIDEND_W-1){1'b0}}};

endpackage

// File: rtl/sdiv_abs.sv
// Purpose: conditional two's complement negate (magnitude of a signed value, or re-apply a sign).
// Latency: combinational.
// Backpressure: none.
module sdiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    // Negating zero yields zero, so a -0 result can never appear.
    always_comb begin
        y_o = neg_i ? (~a_i + 1'b1) : a_i;
    end

endmodule

// File: rtl/system_top_sdiv_54s_32s_seq.sv
// Purpose: radix-2 restoring signed divider, truncating quotient, remainder follows dividend sign.
// Latency: out_valid high after the FIX edge; 56 edges counting the accepting edge.
// Backpressure: single operation in flight; result held in DONE until out_ready, in_ready low meanwhile.
module system_top_sdiv_54s_32s_seq
    import sdiv_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int DW    = DIVIDEND_W;
    localparam int SW    = DIVISOR_W;
    localparam int CNT_W = $clog2(DW);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]   qreg_q;
    logic [SW:0]     rem_q;
    logic [SW:0]     dvs_q;
    logic            qneg_q, rneg_q;
    logic            dbz_pend_q, ovf_pend_q;
    logic [DW-1:0]   quot_q;
    logic [SW-1:0]   rmd_q;
    logic            dbz_q, ovf_q;

    // Dividend magnitude is read as unsigned, so |-2^(DW-1)| is exact in DW bits.
    logic [DW-1:0]   dvd_mag;
    logic [SW:0]     dvs_mag;
    logic [DW-1:0]   q_fix;
    logic [SW-1:0]   r_fix;

    sdiv_abs #(.W(DW)) u_abs_dvd (
        .a_i   (dividend),
        .neg_i (dividend[DW-1]),
        .y_o   (dvd_mag)
    );

    sdiv_abs #(.W(SW+1)) u_abs_dvs (
        .a_i   ({divisor[SW-1], divisor}),
        .neg_i (divisor[SW-1]),
        .y_o   (dvs_mag)
    );

    sdiv_abs #(.W(DW)) u_neg_q (
        .a_i   (qreg_q),
        .neg_i (qneg_q),
        .y_o   (q_fix)
    );

    sdiv_abs #(.W(SW)) u_neg_r (
        .a_i   (rem_q[SW-1:0]),
        .neg_i (rneg_q),
        .y_o   (r_fix)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [SW+1:0] rem_sh;
    logic [SW+1:0] trial;
    logic          geq;
    logic [SW:0]   rem_d;
    always_comb begin
        rem_sh = {rem_q, qreg_q[DW-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        geq    = ~trial[SW+1];
        rem_d  = geq ? trial[SW:0] : rem_sh[SW:0];
    end

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and sign/special-case fix-up.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q      <= '0;
            qreg_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rmd_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    qreg_q     <= dvd_mag;
                    rem_q      <= '0;
                    dvs_q      <= dvs_mag;
                    cnt_q      <= CNT_W'(DW-1);
                    qneg_q     <= dividend[DW-1] ^ divisor[SW-1];
                    rneg_q     <= dividend[DW-1];
                    dbz_pend_q <= (divisor == '0);
                    ovf_pend_q <= (dividend == SQ_MIN) && (divisor == '1);
                    dbz_q      <= 1'b0;
                    ovf_q      <= 1'b0;
                end
                CALC: begin
                    qreg_q <= {qreg_q[DW-2:0], geq};
                    rem_q  <= rem_d;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    if (dbz_pend_q) begin
                        quot_q <= rneg_q ? SQ_MIN : SQ_MAX;
                        rmd_q  <= '0;
                        dbz_q  <= 1'b1;
                    end else if (ovf_pend_q) begin
                        quot_q <= SQ_MAX;
                        rmd_q  <= '0;
                        ovf_q  <= 1'b1;
                    end else begin
                        quot_q <= q_fix;
                        rmd_q  <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
